spi_reg_bank: RTL and testbench

//  Command decoder and register file directly downstream of the SPI slave.

---
 rtl/spi_reg_pkg.sv | 19 +
 rtl/spi_cs_sync.sv | 36 +++
 rtl/spi_reg_bank.sv | 152 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI command decoder / register bank.
package spi_reg_pkg;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam logic        CMD_READ   = 1'b1;
    localparam int unsigned CMD_ADDR_W = 7;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_DATA
    } state_e;

    // True when the upper command address bits beyond the implemented range are clear.
    function automatic logic addr_in_range(input logic [CMD_ADDR_W-1:0] addr,
                                           input int unsigned           aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select plus rising-edge (frame end) detect.
module spi_cs_sync (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_SPI_CS_n,
    output logic o_CS_n_Sync,
    output logic o_Frame_End
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_SPI_CS_n;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the deasserted (high) level so leaving reset never looks like a frame end.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_CS_n_Sync = sync_q;
    assign o_Frame_End = sync_q & ~prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI command decoder and 8-bit register file fed by the SPI slave byte interface.
// Define SPI_REG_AUTO_INC_EN to enable burst access with address auto-increment.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_RX_DV,
    input  logic [7:0]                i_RX_Byte,
    input  logic                      i_SPI_CS_n,
    output logic                      o_TX_DV,
    output logic [7:0]                o_TX_Byte,
    output logic                      o_Wr_Pulse,
    output logic [ADDR_W-1:0]         o_Wr_Addr,
    output logic [8*(2**ADDR_W)-1:0]  o_Regs
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic cs_n_sync;
    logic frame_end;

    spi_cs_sync u_cs_sync (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_SPI_CS_n  (i_SPI_CS_n),
        .o_CS_n_Sync (cs_n_sync),
        .o_Frame_End (frame_end)
    );

    state_e                 state_q, state_d;
    logic                   rw_q, rw_d;
    logic [CMD_ADDR_W-1:0]  addr_q, addr_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];
    logic [CMD_ADDR_W-1:0]  rd_addr;
    logic                   load_tx;
    logic                   data_act;

`ifdef SPI_REG_AUTO_INC_EN
    assign data_act = 1'b1;
`else
    // Without bursts only the first data byte of a frame is acted on.
    logic done_q, done_d;
    assign data_act = ~done_q;
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        regs_d     = regs_q;
        rd_addr    = addr_q;
        load_tx    = 1'b0;
`ifndef SPI_REG_AUTO_INC_EN
        done_d     = done_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // A command coinciding with frame end is still parsed before returning to idle.
                if (i_RX_DV && (!cs_n_sync || frame_end)) begin
                    rw_d    = (i_RX_Byte[CMD_RW_BIT] == CMD_READ);
                    addr_d  = i_RX_Byte[CMD_ADDR_W-1:0];
                    rd_addr = addr_d;
                    load_tx = 1'b1;
                    state_d = ST_DATA;
`ifndef SPI_REG_AUTO_INC_EN
                    done_d  = 1'b0;
`endif
                end
            end
            ST_DATA: begin
                if (i_RX_DV && data_act) begin
                    if (!rw_q && addr_in_range(addr_q, ADDR_W)) begin
                        regs_d[addr_q[ADDR_W-1:0]] = i_RX_Byte;
                        wr_pulse_d                 = 1'b1;
                        wr_addr_d                  = addr_q[ADDR_W-1:0];
                    end
`ifdef SPI_REG_AUTO_INC_EN
                    addr_d  = addr_q + CMD_ADDR_W'(1);
                    rd_addr = addr_d;
                    load_tx = 1'b1;
`else
                    done_d  = 1'b1;
`endif
                end
            end
        endcase

        if (frame_end) begin
            state_d = ST_IDLE;
        end

        // Read data comes from pre-write register contents.
        if (load_tx) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = addr_in_range(rd_addr, ADDR_W) ? regs_q[rd_addr[ADDR_W-1:0]] : 8'h00;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
`ifndef SPI_REG_AUTO_INC_EN
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            regs_q     <= regs_d;
`ifndef SPI_REG_AUTO_INC_EN
            done_q     <= done_d;
`endif
        end
    end

    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Wr_Pulse = wr_pulse_q;
    assign o_Wr_Addr  = wr_addr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign o_Regs[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank; expectations follow SPI_REG_AUTO_INC_EN if defined.
module tb_spi_reg_bank;

    logic         clk;
    logic         rst_l;
    logic         rx_dv;
    logic [7:0]   rx_byte;
    logic         cs_n;
    logic         tx_dv;
    logic [7:0]   tx_byte;
    logic         wr_pulse;
    logic [3:0]   wr_addr;
    logic [127:0] regs;

    int vec_cnt = 0;
    int err_cnt = 0;
    int wr_cnt  = 0;
    int wr_base;

    logic [127:0] exp_regs;
    logic         s_tx_dv, s_tx_dv2, s_wr;
    logic [7:0]   s_tx_byte;
    logic [3:0]   s_wr_addr;

    spi_reg_bank #(
        .ADDR_W  (4),
        .RST_VAL (8'h00)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_RX_DV    (rx_dv),
        .i_RX_Byte  (rx_byte),
        .i_SPI_CS_n (cs_n),
        .o_TX_DV    (tx_dv),
        .o_TX_Byte  (tx_byte),
        .o_Wr_Pulse (wr_pulse),
        .o_Wr_Addr  (wr_addr),
        .o_Regs     (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse === 1'b1) wr_cnt++;

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Drives one RX_DV pulse and captures outputs one and two cycles later.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv     = 1'b0;
        s_tx_dv   = tx_dv;
        s_tx_byte = tx_byte;
        s_wr      = wr_pulse;
        s_wr_addr = wr_addr;
        @(negedge clk);
        s_tx_dv2  = tx_dv;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++; if (tx_dv !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
        vec_cnt++; if (tx_byte !== 8'h00) begin err_cnt++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        vec_cnt++; if (wr_pulse !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_pulse: got %b want 0", wr_pulse); end
        vec_cnt++; if (wr_addr !== 4'h0) begin err_cnt++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL reset_regs: got %h want %h", regs, exp_regs); end
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        wr_base = wr_cnt;
        cs_low();
        send_byte(8'h03);
        vec_cnt++; if (s_tx_dv !== 1'b1) begin err_cnt++; $display("FAIL wr_cmd_tx_dv: got %b want 1", s_tx_dv); end
        vec_cnt++; if (s_tx_dv2 !== 1'b0) begin err_cnt++; $display("FAIL wr_cmd_tx_dv_width: got %b want 0", s_tx_dv2); end
        vec_cnt++; if (s_tx_byte !== 8'h00) begin err_cnt++; $display("FAIL wr_cmd_tx_byte: got %h want 00", s_tx_byte); end
        send_byte(8'h5A);
        exp_regs[8*3 +: 8] = 8'h5A;
        vec_cnt++; if (s_wr !== 1'b1) begin err_cnt++; $display("FAIL wr_pulse: got %b want 1", s_wr); end
        vec_cnt++; if (s_wr_addr !== 4'h3) begin err_cnt++; $display("FAIL wr_addr: got %h want 3", s_wr_addr); end
        cs_high();
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL wr_regs: got %h want %h", regs, exp_regs); end
        vec_cnt++; if (wr_cnt - wr_base !== 1) begin err_cnt++; $display("FAIL wr_count: got %0d want 1", wr_cnt - wr_base); end
    endtask

    task automatic test_read();
        wr_base = wr_cnt;
        cs_low();
        send_byte(8'h83);
        vec_cnt++; if (s_tx_dv !== 1'b1) begin err_cnt++; $display("FAIL rd_tx_dv: got %b want 1", s_tx_dv); end
        vec_cnt++; if (s_tx_byte !== 8'h5A) begin err_cnt++; $display("FAIL rd_tx_byte: got %h want 5a", s_tx_byte); end
        vec_cnt++; if (tx_byte !== 8'h5A) begin err_cnt++; $display("FAIL rd_tx_hold: got %h want 5a", tx_byte); end
        send_byte(8'h77);
`ifdef SPI_REG_AUTO_INC_EN
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_tx_byte !== 8'h00) begin
            err_cnt++; $display("FAIL rd_dummy_tx: got dv=%b byte=%h want dv=1 byte=00", s_tx_dv, s_tx_byte); end
`else
        vec_cnt++; if (s_tx_dv !== 1'b0 || s_tx_byte !== 8'h5A) begin
            err_cnt++; $display("FAIL rd_dummy_tx: got dv=%b byte=%h want dv=0 byte=5a", s_tx_dv, s_tx_byte); end
`endif
        cs_high();
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL rd_regs: got %h want %h", regs, exp_regs); end
        vec_cnt++; if (wr_cnt - wr_base !== 0) begin err_cnt++; $display("FAIL rd_wr_count: got %0d want 0", wr_cnt - wr_base); end
    endtask

    task automatic test_out_of_range();
        wr_base = wr_cnt;
        cs_low();
        send_byte(8'h14);
        send_byte(8'hFF);
        vec_cnt++; if (s_wr !== 1'b0) begin err_cnt++; $display("FAIL oor_wr_pulse: got %b want 0", s_wr); end
        cs_high();
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL oor_regs: got %h want %h", regs, exp_regs); end
        vec_cnt++; if (wr_cnt - wr_base !== 0) begin err_cnt++; $display("FAIL oor_wr_count: got %0d want 0", wr_cnt - wr_base); end
        cs_low();
        send_byte(8'h83);
        cs_high();
        cs_low();
        send_byte(8'h94);
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_tx_byte !== 8'h00) begin
            err_cnt++; $display("FAIL oor_read: got dv=%b byte=%h want dv=1 byte=00", s_tx_dv, s_tx_byte); end
        cs_high();
    endtask

    task automatic test_abort();
        wr_base = wr_cnt;
        cs_low();
        send_byte(8'h05);
        cs_high();
        cs_low();
        send_byte(8'h83);
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_tx_byte !== 8'h5A) begin
            err_cnt++; $display("FAIL abort_new_cmd: got dv=%b byte=%h want dv=1 byte=5a", s_tx_dv, s_tx_byte); end
        vec_cnt++; if (s_wr !== 1'b0) begin err_cnt++; $display("FAIL abort_wr_pulse: got %b want 0", s_wr); end
        cs_high();
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL abort_regs: got %h want %h", regs, exp_regs); end
        vec_cnt++; if (wr_cnt - wr_base !== 0) begin err_cnt++; $display("FAIL abort_wr_count: got %0d want 0", wr_cnt - wr_base); end
    endtask

    // Data byte lands in the same cycle the synchronized frame end is seen.
    task automatic test_byte_at_frame_end();
        cs_low();
        send_byte(8'h07);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = 8'h3C;
        @(negedge clk);
        rx_dv = 1'b0;
        s_wr      = wr_pulse;
        s_wr_addr = wr_addr;
        exp_regs[8*7 +: 8] = 8'h3C;
        vec_cnt++; if (s_wr !== 1'b1 || s_wr_addr !== 4'h7) begin
            err_cnt++; $display("FAIL fe_write: got pulse=%b addr=%h want pulse=1 addr=7", s_wr, s_wr_addr); end
        repeat (5) @(negedge clk);
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL fe_regs: got %h want %h", regs, exp_regs); end
        cs_low();
        send_byte(8'h87);
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_tx_byte !== 8'h3C) begin
            err_cnt++; $display("FAIL fe_idle_cmd: got dv=%b byte=%h want dv=1 byte=3c", s_tx_dv, s_tx_byte); end
        cs_high();
    endtask

    task automatic test_burst();
        wr_base = wr_cnt;
        cs_low();
        send_byte(8'h0E);
        send_byte(8'h11);
        exp_regs[8*14 +: 8] = 8'h11;
`ifdef SPI_REG_AUTO_INC_EN
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_tx_byte !== 8'h00) begin
            err_cnt++; $display("FAIL burst_tx1: got dv=%b byte=%h want dv=1 byte=00", s_tx_dv, s_tx_byte); end
        send_byte(8'h22);
        exp_regs[8*15 +: 8] = 8'h22;
        vec_cnt++; if (s_wr !== 1'b1 || s_wr_addr !== 4'hF) begin
            err_cnt++; $display("FAIL burst_wr2: got pulse=%b addr=%h want pulse=1 addr=f", s_wr, s_wr_addr); end
        send_byte(8'h33);
        vec_cnt++; if (s_wr !== 1'b0) begin err_cnt++; $display("FAIL burst_wr3: got %b want 0", s_wr); end
        cs_high();
        vec_cnt++; if (wr_cnt - wr_base !== 2) begin err_cnt++; $display("FAIL burst_wr_count: got %0d want 2", wr_cnt - wr_base); end
`else
        send_byte(8'h22);
        vec_cnt++; if (s_tx_dv !== 1'b0 || s_wr !== 1'b0) begin
            err_cnt++; $display("FAIL burst_ignored: got dv=%b pulse=%b want dv=0 pulse=0", s_tx_dv, s_wr); end
        send_byte(8'h33);
        cs_high();
        vec_cnt++; if (wr_cnt - wr_base !== 1) begin err_cnt++; $display("FAIL burst_wr_count: got %0d want 1", wr_cnt - wr_base); end
`endif
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL burst_regs: got %h want %h", regs, exp_regs); end
    endtask

    task automatic test_reset_mid_frame();
        cs_low();
        send_byte(8'h02);
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        exp_regs = '0;
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL rstmid_regs: got %h want %h", regs, exp_regs); end
        vec_cnt++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00 || wr_pulse !== 1'b0 || wr_addr !== 4'h0) begin
            err_cnt++; $display("FAIL rstmid_outputs: got dv=%b byte=%h pulse=%b addr=%h want all 0",
                                tx_dv, tx_byte, wr_pulse, wr_addr); end
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h44);
        vec_cnt++; if (s_tx_dv !== 1'b1 || s_wr !== 1'b0) begin
            err_cnt++; $display("FAIL rstmid_as_cmd: got dv=%b pulse=%b want dv=1 pulse=0", s_tx_dv, s_wr); end
        cs_high();
        vec_cnt++; if (regs !== exp_regs) begin err_cnt++; $display("FAIL rstmid_regs_after: got %h want %h", regs, exp_regs); end
    endtask

    initial begin
        rst_l    = 1'b0;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        cs_n     = 1'b1;
        exp_regs = '0;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_abort();
        test_byte_at_frame_end();
        test_burst();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
